// File: rtl/mem_addr_decoder_n_if.sv
// mem_addr_decoder_n_if: native valid/ready memory bus, N lanes of valid/ready/rdata sharing addr/wdata/wstrb
// Ports (signals): valid[N], ready[N], addr[32], wdata[32], wstrb[4] (0 = read), rdata[N*32] packed per lane
interface mem_addr_decoder_n_if #(parameter int N = 1);
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic [N*32-1:0] rdata;
  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_addr_decoder_n.sv
// mem_addr_decoder_n: 1-to-NUM_CH memory bus decoder with latched channel select, registered response and error answers
// Ports: clk, resetn (async active-low); s_mem (upstream CPU bus, slave side); m_mem (NUM_CH downstream channels, master side);
//        err_pulse (one-cycle on error response), err_timeout (last error was a timeout), err_addr (address of last error)
// Optional: define MEM_DECODER_TIMEOUT_EN to enable the ACTIVE-state watchdog; otherwise ACTIVE waits forever
module mem_addr_decoder_n #(
  parameter int                   NUM_CH    = 4,
  parameter logic [NUM_CH*32-1:0] BASE_ADDR = {32'h03000000, 32'h02000000, 32'h01000000, 32'h00000000},
  parameter logic [NUM_CH*32-1:0] ADDR_MASK = {4{32'hFF000000}},
  parameter int                   TIMEOUT   = 255,
  parameter logic [31:0]          ERR_RDATA = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  mem_addr_decoder_n_if.slave   s_mem,
  mem_addr_decoder_n_if.master  m_mem,
  output logic                  err_pulse,
  output logic                  err_timeout,
  output logic [31:0]           err_addr
);
  localparam int SW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;
  state_t          state;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   hit_idx;
  logic            hit;
  logic [31:0]     rdata_r;
  // Descending scan so the lowest matching channel wins on overlap
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (((BASE_ADDR[32*i +: 32] ^ s_mem.addr) & ADDR_MASK[32*i +: 32]) == 32'd0) begin
        hit = 1'b1;
        hit_idx = SW'(i);
      end
  end
  assign m_mem.valid = state == ACTIVE ? NUM_CH'(s_mem.valid) << sel : '0;
  assign m_mem.addr  = s_mem.addr;
  assign m_mem.wdata = s_mem.wdata;
  assign m_mem.wstrb = s_mem.wstrb;
  assign s_mem.ready = state == RESP;
  assign s_mem.rdata = rdata_r;
`ifdef MEM_DECODER_TIMEOUT_EN
  logic [15:0] wdog;
  logic        to_r;
  assign err_timeout = to_r;
`else
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      sel <= '0;
      rdata_r <= '0;
      err_pulse <= 1'b0;
      err_addr <= '0;
`ifdef MEM_DECODER_TIMEOUT_EN
      wdog <= '0;
      to_r <= 1'b0;
`endif
    end else begin
      err_pulse <= 1'b0;
`ifdef MEM_DECODER_TIMEOUT_EN
      // Held at zero outside ACTIVE, so it starts from zero on every entry
      wdog <= state == ACTIVE ? wdog + 16'd1 : 16'd0;
`endif
      case (state)
        IDLE:
          if (s_mem.valid[0]) begin
            if (hit) begin
              sel <= hit_idx;
              state <= ACTIVE;
            end else begin
              rdata_r <= ERR_RDATA;
              err_addr <= s_mem.addr;
              err_pulse <= 1'b1;
`ifdef MEM_DECODER_TIMEOUT_EN
              to_r <= 1'b0;
`endif
              state <= RESP;
            end
          end
        ACTIVE:
          if (!s_mem.valid[0])
            state <= IDLE;
          else if (m_mem.ready[sel]) begin
            rdata_r <= m_mem.rdata[32*sel +: 32];
            state <= RESP;
          end
`ifdef MEM_DECODER_TIMEOUT_EN
          else if (wdog == 16'(TIMEOUT)) begin
            rdata_r <= ERR_RDATA;
            err_addr <= s_mem.addr;
            err_pulse <= 1'b1;
            to_r <= 1'b1;
            state <= RESP;
          end
`endif
        default:
          state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_addr_decoder_n.sv
// tb_mem_addr_decoder_n: directed bench with a transaction-level model checked every cycle
module tb_mem_addr_decoder_n;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  localparam int TO = 8;
`ifdef MEM_DECODER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  mem_addr_decoder_n_if #(.N(1)) up ();
  mem_addr_decoder_n_if #(.N(4)) dn ();
  mem_addr_decoder_n_if #(.N(1)) up2 ();
  mem_addr_decoder_n_if #(.N(4)) dn2 ();
  logic err_pulse, err_timeout, err_pulse2, err_timeout2;
  logic [31:0] err_addr, err_addr2;
  mem_addr_decoder_n #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .s_mem(up), .m_mem(dn),
    .err_pulse(err_pulse), .err_timeout(err_timeout), .err_addr(err_addr));
  mem_addr_decoder_n #(.TIMEOUT(TO),
    .BASE_ADDR({32'h03000000, 32'h02000000, 32'h00000000, 32'h00000000})) dut2 (
    .clk(clk), .resetn(resetn), .s_mem(up2), .m_mem(dn2),
    .err_pulse(err_pulse2), .err_timeout(err_timeout2), .err_addr(err_addr2));
  int n_chk = 0;
  int n_fail = 0;
  int wait_cfg [4];
  logic [31:0] mem_data [4];
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  // Memory map: top byte selects channel 0..3, anything else is unmapped
  function automatic int decode(logic [31:0] a);
    return a[31:24] < 8'd4 ? int'(a[31:24]) : -1;
  endfunction
  // Slave channels: channel i raises ready on its (wait_cfg[i]+1)-th valid cycle
  initial begin
    int cnt [4];
    dn.ready = '0;
    dn.rdata = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        dn.rdata[32*i +: 32] = mem_data[i];
        dn.ready[i] = dn.valid[i] && cnt[i] == wait_cfg[i];
        cnt[i] = dn.valid[i] ? cnt[i] + 1 : 0;
      end
    end
  end
  // Per-cycle compare against the transaction model
  initial begin
    int vcnt;
    int d;
    logic prev;
    vcnt = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        vcnt = 0;
        prev = 1'b0;
      end else begin
        check("addr_pass", dn.addr, up.addr);
        check("wdata_pass", dn.wdata, up.wdata);
        check("wstrb_pass", 32'(dn.wstrb), 32'(up.wstrb));
        d = decode(up.addr);
        if (dn.valid != 4'd0) begin
          check("valid_onehot", 32'(dn.valid), (d < 0 || !up.valid[0]) ? 32'd0 : 32'd1 << d);
          vcnt++;
        end
        if (up.ready[0]) begin
          check("ready_pulse", 32'(prev), 32'd0);
          if (d < 0) begin
            check("dec_vcnt", vcnt, 0);
            check("dec_rdata", up.rdata, ERR);
            check("dec_pulse", 32'(err_pulse), 32'd1);
            check("dec_to", 32'(err_timeout), 32'd0);
            check("dec_addr", err_addr, up.addr);
          end else if (TO_EN && wait_cfg[d] > TO) begin
            check("to_vcnt", vcnt, TO + 1);
            check("to_rdata", up.rdata, ERR);
            check("to_pulse", 32'(err_pulse), 32'd1);
            check("to_flag", 32'(err_timeout), 32'd1);
            check("to_addr", err_addr, up.addr);
          end else begin
            check("ok_vcnt", vcnt, wait_cfg[d] + 1);
            check("ok_rdata", up.rdata, mem_data[d]);
            check("ok_pulse", 32'(err_pulse), 32'd0);
          end
          vcnt = 0;
        end else begin
          check("pulse_idle", 32'(err_pulse), 32'd0);
          if (!up.valid[0]) vcnt = 0;
        end
        prev = up.ready[0];
      end
    end
  end
  task automatic txn(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                     output int n, output logic [31:0] rd, output logic ep);
    @(posedge clk);
    #1;
    up.valid = 1'b1;
    up.addr = a;
    up.wstrb = ws;
    up.wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!up.ready[0] && n < 100);
    check("txn_done", 32'(up.ready), 32'd1);
    rd = up.rdata;
    ep = err_pulse;
    @(posedge clk);
    #1;
    up.valid = 1'b0;
  endtask
  initial begin
    int n;
    logic [31:0] rd;
    logic ep;
    logic [3:0] seen;
    logic any_ready;
    up.valid = 1'b0;
    up.addr = '0;
    up.wdata = '0;
    up.wstrb = '0;
    up2.valid = 1'b0;
    up2.addr = '0;
    up2.wdata = '0;
    up2.wstrb = '0;
    dn2.ready = 4'hF;
    dn2.rdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'hC0C0C0C0};
    mem_data = '{32'h0A0A0A0A, 32'h12345678, 32'h22222222, 32'h33333333};
    wait_cfg = '{0, 0, 0, 0};
    #12;
    check("rst_valid", 32'(dn.valid), 32'd0);
    check("rst_ready", 32'(up.ready), 32'd0);
    check("rst_rdata", up.rdata, 32'd0);
    check("rst_pulse", 32'(err_pulse), 32'd0);
    check("rst_to", 32'(err_timeout), 32'd0);
    check("rst_eaddr", err_addr, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    txn(32'h01000010, 4'h0, 32'h0, n, rd, ep);
    check("t1_lat", n, 3);
    check("t1_rdata", rd, 32'h12345678);
    check("t1_pulse", 32'(ep), 32'd0);
    wait_cfg[2] = 5;
    txn(32'h02000004, 4'hF, 32'hA5A5A5A5, n, rd, ep);
    check("t2_lat", n, 8);
    check("t2_rdata", rd, 32'h22222222);
    txn(32'h05000000, 4'h0, 32'h0, n, rd, ep);
    check("t3_lat", n, 2);
    check("t3_rdata", rd, ERR);
    check("t3_pulse", 32'(ep), 32'd1);
    check("t3_eaddr", err_addr, 32'h05000000);
    check("t3_to", 32'(err_timeout), 32'd0);
    txn(32'h03FFFFFC, 4'h3, 32'h01020304, n, rd, ep);
    check("top_lat", n, 3);
    check("top_rdata", rd, 32'h33333333);
    txn(32'h04000000, 4'h0, 32'h0, n, rd, ep);
    check("unm_lat", n, 2);
    check("unm_rdata", rd, ERR);
    txn(32'h00FFFFFC, 4'h0, 32'h0, n, rd, ep);
    check("ch0_rdata", rd, 32'h0A0A0A0A);
    check("eaddr_hold", err_addr, 32'h04000000);
`ifdef MEM_DECODER_TIMEOUT_EN
    wait_cfg[3] = 1000;
    txn(32'h03000000, 4'h0, 32'h0, n, rd, ep);
    check("t4_lat", n, TO + 3);
    check("t4_rdata", rd, ERR);
    check("t4_pulse", 32'(ep), 32'd1);
    check("t4_to", 32'(err_timeout), 32'd1);
    check("t4_eaddr", err_addr, 32'h03000000);
    wait_cfg[1] = TO;
    txn(32'h01000000, 4'h0, 32'h0, n, rd, ep);
    check("race_lat", n, TO + 3);
    check("race_rdata", rd, 32'h12345678);
    check("race_pulse", 32'(ep), 32'd0);
    check("race_to_hold", 32'(err_timeout), 32'd1);
    wait_cfg[1] = 0;
`else
    wait_cfg[3] = 1000;
    @(posedge clk);
    #1;
    up.valid = 1'b1;
    up.addr = 32'h03000000;
    up.wstrb = 4'h0;
    any_ready = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_ready |= up.ready[0];
    end
    check("stall_noresp", 32'(any_ready), 32'd0);
    check("stall_valid", 32'(dn.valid), 32'h8);
    @(posedge clk);
    #1 up.valid = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(dn.valid), 32'd0);
    check("abort_ready", 32'(up.ready), 32'd0);
    @(negedge clk);
    check("abort_ready2", 32'(up.ready), 32'd0);
    check("abort_to", 32'(err_timeout), 32'd0);
    wait_cfg[3] = 0;
    txn(32'h03000100, 4'h0, 32'h0, n, rd, ep);
    check("after_abort_lat", n, 3);
    check("after_abort_rd", rd, 32'h33333333);
`endif
    wait_cfg[0] = 1000;
    @(posedge clk);
    #1;
    up.valid = 1'b1;
    up.addr = 32'h00000100;
    up.wstrb = 4'h0;
    repeat (3) @(negedge clk);
    check("t6_valid_pre", 32'(dn.valid), 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("t6_valid", 32'(dn.valid), 32'd0);
    check("t6_ready", 32'(up.ready), 32'd0);
    check("t6_rdata", up.rdata, 32'd0);
    check("t6_eaddr", err_addr, 32'd0);
    check("t6_pulse", 32'(err_pulse), 32'd0);
    check("t6_to", 32'(err_timeout), 32'd0);
    up.valid = 1'b0;
    wait_cfg[0] = 0;
    @(posedge clk);
    #1 resetn = 1'b1;
    txn(32'h00000040, 4'h0, 32'h0, n, rd, ep);
    check("t6_after_lat", n, 3);
    check("t6_after_rd", rd, 32'h0A0A0A0A);
    @(posedge clk);
    #1;
    up2.addr = 32'h00000020;
    up2.valid = 1'b1;
    seen = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      seen |= dn2.valid;
    end while (!up2.ready[0] && n < 20);
    check("t5_seen", 32'(seen), 32'h1);
    check("t5_lat", n, 3);
    check("t5_rdata", up2.rdata, 32'hC0C0C0C0);
    @(posedge clk);
    #1 up2.valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_addr_decoder_n.md
Name: mem_addr_decoder_n

Overview:
Parametrised 1-to-NUM_CH address decoder for the native valid/ready memory bus (addr/wdata/wstrb/rdata). It sits between the CPU memory port and the peripheral slaves.
- Generalises the fixed 4-way combinational mux to any channel count.
- Latches the selected channel per transaction and registers the read response.
- Answers unmapped addresses itself with an error response.
- Optionally aborts stalled transactions through a watchdog.

Parameters:
NUM_CH, 4, number of downstream channels (1..8)
BASE_ADDR, {32'h03000000,32'h02000000,32'h01000000,32'h00000000}, packed NUM_CH*32 base addresses; channel i at bits [32*i+:32]
ADDR_MASK, {4{32'hFF000000}}, packed NUM_CH*32 compare masks; channel i at bits [32*i+:32]
TIMEOUT, 255, watchdog limit in cycles spent in ACTIVE (1..65535)
ERR_RDATA, 32'hDEADBEEF, rdata returned on decode error or timeout

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
s_mem_valid  in  1  upstream request valid
s_mem_ready  out  1  upstream response strobe, one-cycle pulse
s_mem_addr  in  32  request address
s_mem_wdata  in  32  write data
s_mem_wstrb  in  4  byte strobes; 0 means read
s_mem_rdata  out  32  registered read data
m_mem_valid  out  NUM_CH  per-channel valid
m_mem_ready  in  NUM_CH  per-channel ready
m_mem_addr  out  32  shared, equals s_mem_addr
m_mem_wdata  out  32  shared, equals s_mem_wdata
m_mem_wstrb  out  4  shared, equals s_mem_wstrb
m_mem_rdata  in  NUM_CH*32  packed per-channel read data
err_pulse  out  1  one-cycle pulse on decode error or timeout
err_timeout  out  1  sticky: last error was a timeout (0 means decode error)
err_addr  out  32  address of the last errored request

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE; all m_mem_valid=0, s_mem_ready=0, s_mem_rdata=0.
  - err_pulse=0, err_timeout=0, err_addr=0, watchdog counter=0.
- Decode rule: hit[i] = ((BASE_ADDR_i ^ s_mem_addr) & ADDR_MASK_i) == 0.
  - Overlapping hits resolve to the lowest index.
  - No hit is a decode error.
- m_mem_addr, m_mem_wdata and m_mem_wstrb are combinational pass-throughs of the s_mem inputs.
- States: IDLE, ACTIVE, RESP.
- IDLE:
  - s_mem_valid=1 with a hit: latch sel=index, go to ACTIVE. No m_mem_valid in this cycle.
  - s_mem_valid=1 with no hit: rdata_r<=ERR_RDATA, err_addr<=s_mem_addr, err_timeout<=0, err_pulse<=1, go to RESP.
- ACTIVE:
  - m_mem_valid[sel]=s_mem_valid; all other channels are 0. Watchdog counts up each cycle.
  - m_mem_ready[sel]=1: rdata_r<=m_mem_rdata[sel], go to RESP. m_mem_valid drops combinationally the following cycle.
  - Ready on a non-selected channel is ignored.
  - s_mem_valid drops (protocol violation): return to IDLE, no response.
- RESP:
  - s_mem_ready=1 for exactly one cycle; s_mem_rdata=rdata_r; go to IDLE.
  - A new request is accepted no earlier than the next cycle.
- Latency: minimum 3 cycles from s_mem_valid rise to s_mem_ready, with a zero-wait slave (IDLE, ACTIVE, RESP).
- Decode error latency: 2 cycles.
- s_mem_rdata holds its last value outside RESP. Writes return whatever was captured and must be ignored by the CPU.
- err_pulse is high only in the RESP cycle of an errored transaction.
- err_addr and err_timeout hold until the next error.
- Reset asserted mid-transaction: immediate return to IDLE, all valids deassert, no response.
- NUM_CH=1 is legal; sel is a 1-bit register held at 0.

Optional Feature:
Macro: MEM_DECODER_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to ACTIVE.
  - When the counter reaches TIMEOUT with no ready: m_mem_valid[sel] drops next cycle, rdata_r<=ERR_RDATA, err_timeout<=1, err_addr<=s_mem_addr, err_pulse in RESP, go to RESP.
  - Ready arriving in the same cycle as expiry wins: normal response, no error.
- Not defined:
  - Counter logic is absent; ACTIVE waits indefinitely.
  - err_timeout is tied to 0.

Test Plan:
1. Read 0x01000010, ch1 zero-wait returning 0x12345678 -> m_mem_valid=4'b0010 for 1 cycle; s_mem_ready 3 cycles after valid with rdata=0x12345678; no err_pulse.
2. Write 0x02000004 wdata=0xA5A5A5A5 wstrb=4'hF, ch2 ready after 5 waits -> ch2 sees addr/wdata/wstrb unchanged; only valid[2] is ever high; a single s_mem_ready pulse follows.
3. Read 0x05000000 (unmapped) -> no m_mem_valid; s_mem_ready 2 cycles later with rdata=0xDEADBEEF; err_pulse=1, err_addr=0x05000000, err_timeout=0.
4. With MEM_DECODER_TIMEOUT_EN and TIMEOUT=8, ch3 never ready -> valid[3] high for 9 cycles then drops; s_mem_ready with 0xDEADBEEF; err_timeout=1.
5. Set BASE_ADDR1=BASE_ADDR0=0, read 0x00000020 -> only ch0 is selected.
6. resetn pulsed low during ACTIVE with ch0 stalled -> all outputs 0 asynchronously; the next request after release completes normally.
